// File: rtl/csa_resolve_seq.sv
// csa_resolve_seq: chunked carry-propagate resolver turning a redundant (sum, carry) pair into binary; optional zero flag under CSA_RESOLVE_ZFLAG_EN
module csa_resolve_seq #(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         nRST,
    input  logic [N:0]   iSum,
    input  logic [N:0]   iCarry,
    input  logic         iValid,
    output logic         oReady,
    output logic [N+1:0] oResult,
    output logic         oValid,
`ifdef CSA_RESOLVE_ZFLAG_EN
    output logic         oZero,
`endif
    input  logic         iReady
);
    localparam int W  = N + 2;
    localparam int K  = (W + CHUNK - 1) / CHUNK;
    localparam int EW = K * CHUNK;
    localparam int IW = $clog2(K + 1);
    localparam logic [IW-1:0] LAST  = IW'(K);
    localparam logic [W-1:0]  CMASK = W'({CHUNK{1'b1}});

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t         state;
    logic [EW-1:0]  opSum;
    logic [EW-1:0]  opCarry;
    logic [W-1:0]   result;
    logic [IW-1:0]  idx;
    logic           cy;
    logic [CHUNK-1:0] chunkSum;
    logic           chunkCo;

    assign {chunkCo, chunkSum} = {1'b0, opSum[CHUNK-1:0]} + {1'b0, opCarry[CHUNK-1:0]} + (CHUNK + 1)'(cy);
    assign oResult = result;

    // Handshake FSM: accept in IDLE, resolve one chunk per ADD cycle (plus one closing cycle), hold in DONE until taken
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            oReady  <= 1'b1;
            oValid  <= 1'b0;
            opSum   <= '0;
            opCarry <= '0;
            result  <= '0;
            idx     <= '0;
            cy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (iValid) begin
                    opSum   <= EW'(iSum);
                    opCarry <= EW'(iCarry);
                    idx     <= '0;
                    cy      <= 1'b0;
                    oReady  <= 1'b0;
                    state   <= ADD;
                end
                ADD: if (idx == LAST) begin
                    oValid <= 1'b1;
                    state  <= DONE;
                end else begin
                    result  <= (result & ~(CMASK << (idx * CHUNK))) | (W'(chunkSum) << (idx * CHUNK));
                    opSum   <= opSum >> CHUNK;
                    opCarry <= opCarry >> CHUNK;
                    cy      <= chunkCo;
                    idx     <= idx + 1'b1;
                end
                DONE: if (iReady) begin
                    oValid <= 1'b0;
                    oReady <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CSA_RESOLVE_ZFLAG_EN
    logic zAcc;

    // OR of every written chunk; its complement is latched as oZero on entry to DONE
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            zAcc  <= 1'b0;
            oZero <= 1'b0;
        end else if (state == IDLE) begin
            zAcc  <= 1'b0;
            oZero <= 1'b0;
        end else if (state == ADD) begin
            if (idx == LAST) oZero <= ~zAcc;
            else zAcc <= zAcc | (|chunkSum);
        end else if (iReady) begin
            oZero <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_csa_resolve_seq.sv
// tb_csa_resolve_seq: scoreboard bench running directed and reducer-chained vectors through four chunk widths
module tb_csa_resolve_seq;
    localparam int N = 32;
    localparam int W = N + 2;
    localparam int CH[4] = '{8, 1, 5, 34};

    typedef struct {
        logic [W-1:0] res;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int inst, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s chunk=%0d actual=%h required=%h", name, CH[inst], act, req);
        end
    endtask

    // bit-level 4:2 compressor with a horizontal carry chain, standing in for the upstream reducer
    function automatic void reduce42(input logic [N-1:0] a0, input logic [N-1:0] a1, input logic [N-1:0] a2,
                                     input logic [N-1:0] a3, input logic cin, output logic [N:0] s, output logic [N:0] c);
        logic ci, t, co;
        ci = cin;
        s = '0;
        c = '0;
        for (int i = 0; i < N; i++) begin
            t      = a0[i] ^ a1[i] ^ a2[i];
            co     = (a0[i] & a1[i]) | (a0[i] & a2[i]) | (a1[i] & a2[i]);
            s[i]   = t ^ a3[i] ^ ci;
            c[i+1] = (t & a3[i]) | (t & ci) | (a3[i] & ci);
            ci     = co;
        end
        s[N] = ci;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : gen
        localparam int CHUNK = CH[g];
        localparam int K = (W + CHUNK - 1) / CHUNK;

        logic         nRST = 1'b1;
        logic         iValid = 1'b0;
        logic         iReady = 1'b0;
        logic [N:0]   iSum = '0;
        logic [N:0]   iCarry = '0;
        logic         oReady;
        logic         oValid;
        logic [W-1:0] oResult;
`ifdef CSA_RESOLVE_ZFLAG_EN
        logic         oZero;
`endif
        bit           done = 1'b0;
        exp_t         q[$];

        csa_resolve_seq #(.N(N), .CHUNK(CHUNK)) dut (
            .clk(clk),
            .nRST(nRST),
            .iSum(iSum),
            .iCarry(iCarry),
            .iValid(iValid),
            .oReady(oReady),
            .oResult(oResult),
            .oValid(oValid),
`ifdef CSA_RESOLVE_ZFLAG_EN
            .oZero(oZero),
`endif
            .iReady(iReady)
        );

        task automatic send(input logic [N:0] s, input logic [N:0] c, input logic [W-1:0] r);
            int n;
            n = 0;
            @(negedge clk);
            while (!oReady && n < 4 * K + 20) begin
                @(negedge clk);
                n++;
            end
            check("ready_wait", g, oReady, 1);
            iSum   = s;
            iCarry = c;
            iValid = 1'b1;
            q.push_back('{r, cyc + 1});
            @(negedge clk);
            iValid = 1'b0;
        endtask

        task automatic waitValid();
            int n;
            n = 0;
            while (!oValid && n < 4 * K + 20) begin
                @(negedge clk);
                n++;
            end
            check("valid_wait", g, oValid, 1);
        endtask

        task automatic take();
            waitValid();
            if (oValid) begin
                iReady = 1'b1;
                @(negedge clk);
                iReady = 1'b0;
            end
        endtask

        // monitor: pops the scoreboard on each rising oValid and checks value, latency and stability while held
        initial begin : monitor
            logic         pv;
            logic [W-1:0] held;
            exp_t         e;
            pv   = 1'b0;
            held = '0;
            forever begin
                @(negedge clk);
                if (oValid && !pv) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_result chunk=%0d actual=%h required=none", CHUNK, oResult);
                    end else begin
                        e = q.pop_front();
                        check("result", g, oResult, e.res);
                        check("latency", g, cyc - e.acc, K + 1);
`ifdef CSA_RESOLVE_ZFLAG_EN
                        check("zero_flag", g, oZero, e.res == '0);
`endif
                    end
                    held = oResult;
                end else if (oValid && pv) begin
                    check("hold_result", g, oResult, held);
                end
                pv = oValid;
            end
        end

        // stimulus: reset, directed corners, backpressure, reset mid-ADD, then reducer-chained random pairs
        initial begin : drive
            logic [N-1:0] a[4];
            logic         cin;
            logic [N:0]   s, c;
            logic [W-1:0] sum;
            #1 nRST = 1'b0;
            repeat (2) @(negedge clk);
            check("reset_ready", g, oReady, 1);
            check("reset_valid", g, oValid, 0);
            check("reset_result", g, oResult, 0);
`ifdef CSA_RESOLVE_ZFLAG_EN
            check("reset_zero", g, oZero, 0);
`endif
            nRST = 1'b1;
            send(33'h0_FFFF_FFFF, 33'h0_0000_0001, 34'h1_0000_0000); take();
            send(33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 34'h3_FFFF_FFFE); take();
            send(33'h0, 33'h0, 34'h0); take();
            send(33'h1_2345_6789, 33'h0_FEDC_BA98, 34'h2_2222_2221); take();
            send(33'h0_AAAA_AAAA, 33'h0_5555_5555, 34'h0_FFFF_FFFF); take();
            send(33'h1_0000_0000, 33'h1_0000_0000, 34'h2_0000_0000); take();
            send(33'h5, 33'h7, 34'hC);
            waitValid();
            repeat (4) begin
                iValid = ~iValid;
                iSum   = N'($urandom);
                iCarry = N'($urandom);
                @(negedge clk);
                check("bp_ready", g, oReady, 0);
                check("bp_valid", g, oValid, 1);
            end
            iValid = 1'b0;
            iReady = 1'b1;
            @(negedge clk);
            iReady = 1'b0;
            check("release_valid", g, oValid, 0);
            check("release_ready", g, oReady, 1);
            repeat (K + 3) @(negedge clk);
            check("no_accept", g, oValid, 0);
            send(33'h1_2345_6789, 33'h0_1111_1111, 34'h1_3456_789A);
            repeat ((K >= 2) ? 2 : 1) @(posedge clk);
            #2 nRST = 1'b0;
            #1;
            check("midrst_valid", g, oValid, 0);
            check("midrst_ready", g, oReady, 1);
            check("midrst_result", g, oResult, 0);
`ifdef CSA_RESOLVE_ZFLAG_EN
            check("midrst_zero", g, oZero, 0);
`endif
            q.delete();
            @(negedge clk);
            nRST = 1'b1;
            send(33'h5, 33'h3, 34'h8); take();
            for (int i = 0; i < 100; i++) begin
                for (int j = 0; j < 4; j++) a[j] = $urandom;
                cin = 1'($urandom);
                reduce42(a[0], a[1], a[2], a[3], cin, s, c);
                sum = W'(a[0]) + W'(a[1]) + W'(a[2]) + W'(a[3]) + W'(cin);
                send(s, c, sum);
                take();
            end
            repeat (3) @(negedge clk);
            check("queue_drained", g, q.size(), 0);
            done = 1'b1;
        end
    end

    initial begin : summary
        int n;
        n = 0;
        while (!(gen[0].done && gen[1].done && gen[2].done && gen[3].done) && n < 60000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!(gen[0].done && gen[1].done && gen[2].done && gen[3].done)) begin
            bad++;
            $display("FAIL run_timeout actual=%0d cycles required=completion", n);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
